mem_arbiter: RTL and testbench

Two-port arbiter that shares the single block-wide `data_memory` (6-bit block address, 32-bit block, busywait handshake) between the instruction cache (port 0) and the data cache (port 1). Sits between both cache controllers and main memory; each cache sees a `data_memory`-compatible port. One memory transaction is in flight at a time; readdata is registered per port and returned on completion.

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one data_memory between icache (port 0) and dcache (port 1); ties: port 1 wins, or alternate under MEM_ARB_ROUND_ROBIN_EN.
// Latency: strobe one cycle after the request edge, done one edge after mem_busywait falls; busywait_n low for that single DONE cycle.
// Backpressure: busywait_n stalls each requester until its own DONE cycle; one memory transaction in flight at a time.
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        read0,
    input  logic        write0,
    input  logic [5:0]  address0,
    input  logic [31:0] writedata0,
    output logic [31:0] readdata0,
    output logic        busywait0,
    input  logic        read1,
    input  logic        write1,
    input  logic [5:0]  address1,
    input  logic [31:0] writedata1,
    output logic [31:0] readdata1,
    output logic        busywait1,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, DONE0, DONE1} state_t;

    state_t state, state_next;
    logic   started;
    logic   last_grant;
    logic   req0, req1;
    logic   tie_pick1;
    logic   finish;

    assign req0   = read0 | write0;
    assign req1   = read1 | write1;
    assign finish = started & ~mem_busywait;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_pick1 = (last_grant == 1'b0);
`else
    // Fixed priority; last_grant is still tracked so both builds share state.
    assign tie_pick1 = last_grant | 1'b1;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_next = tie_pick1 ? GRANT1 : GRANT0;
                else if (req1)
                    state_next = GRANT1;
                else if (req0)
                    state_next = GRANT0;
            end
            GRANT0:  if (finish) state_next = DONE0;
            GRANT1:  if (finish) state_next = DONE1;
            DONE0:   state_next = req1 ? GRANT1 : IDLE;
            DONE1:   state_next = req0 ? GRANT0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A simultaneous read+write on one port is issued as a write.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 6'd0;
        mem_writedata = 32'd0;
        case (state)
            GRANT0: begin
                mem_read      = read0 & ~write0;
                mem_write     = write0;
                mem_address   = address0;
                mem_writedata = writedata0;
            end
            GRANT1: begin
                mem_read      = read1 & ~write1;
                mem_write     = write1;
                mem_address   = address1;
                mem_writedata = writedata1;
            end
            default: ;
        endcase
    end

    assign busywait0 = req0 && (state != DONE0);
    assign busywait1 = req1 && (state != DONE1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            started    <= 1'b0;
            last_grant <= 1'b1;
            readdata0  <= 32'd0;
            readdata1  <= 32'd0;
        end else begin
            state <= state_next;
            // Only a busy->idle fall after a seen busy counts as completion.
            if (state == GRANT0 || state == GRANT1) begin
                if (mem_busywait)
                    started <= 1'b1;
            end else begin
                started <= 1'b0;
            end
            if (state_next == GRANT0 && state != GRANT0)
                last_grant <= 1'b0;
            else if (state_next == GRANT1 && state != GRANT1)
                last_grant <= 1'b1;
            if (state == GRANT0 && finish && read0 && !write0)
                readdata0 <= mem_readdata;
            if (state == GRANT1 && finish && read1 && !write1)
                readdata1 <= mem_readdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + randomized bench for mem_arbiter with a latency-programmable memory model and transaction-level reference.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        read0 = 1'b0, write0 = 1'b0, read1 = 1'b0, write1 = 1'b0;
    logic [5:0]  address0 = '0, address1 = '0;
    logic [31:0] writedata0 = '0, writedata1 = '0;
    logic [31:0] readdata0, readdata1;
    logic        busywait0, busywait1;
    logic        mem_read, mem_write, mem_busywait;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .read0(read0), .write0(write0), .address0(address0), .writedata0(writedata0),
        .readdata0(readdata0), .busywait0(busywait0),
        .read1(read1), .write1(write1), .address1(address1), .writedata1(writedata1),
        .readdata1(readdata1), .busywait1(busywait1),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 clock = ~clock;

    // Memory: busy for mem_lat cycles starting with the first strobe cycle; needs the strobe to drop between accesses.
    logic [31:0] store [64];
    logic [31:0] mrd = '0;
    int          mem_lat = 1;
    int          mcnt = 0;
    bit          mfin = 1'b0;

    assign mem_busywait = (mem_read | mem_write) & ~mfin;
    assign mem_readdata = mrd;

    always @(posedge clock) begin
        if (!(mem_read || mem_write)) begin
            mcnt <= 0;
            mfin <= 1'b0;
        end else if (!mfin) begin
            if (mcnt + 1 >= mem_lat) begin
                mfin <= 1'b1;
                if (mem_write) store[mem_address] <= mem_writedata;
                else           mrd <= store[mem_address];
            end
            mcnt <= mcnt + 1;
        end
    end

    // Reference: memory image, expected readdata per port, last granted port.
    logic [31:0] ref_mem [64];
    logic [31:0] exp_rd [2];
    int          lg = 1;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit r0, input bit w0, input logic [5:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input logic [5:0] a1, input logic [31:0] d1,
                       input int lat, input int rst_at);
        bit          rq [2], wq [2], act [2], done [2];
        logic [5:0]  aq [2];
        logic [31:0] dq [2], comp [2], cur [2];
        int          order [2], stall [2], first_s [2], done_c [2];
        int          n, idx, cyc, p;
        rq = '{r0, r1}; wq = '{w0, w1}; aq = '{a0, a1}; dq = '{d0, d1};
        act = '{r0 | w0, r1 | w1};
        cur = exp_rd;
        n = 0;
        if (act[0] && act[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            order[0] = (lg == 1) ? 0 : 1;
`else
            order[0] = 1;
`endif
            order[1] = 1 - order[0];
            n = 2;
        end else if (act[0] || act[1]) begin
            order[0] = act[0] ? 0 : 1;
            n = 1;
        end
        if (rst_at > 0) begin
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end
        for (int i = 0; i < n; i++) begin
            p = order[i];
            lg = p;
            if (wq[p])      ref_mem[aq[p]] = dq[p];
            else if (rq[p]) exp_rd[p] = ref_mem[aq[p]];
            comp[p] = exp_rd[p];
        end
        mem_lat = lat;
        @(posedge clock); #1;
        read0 = r0; write0 = w0; address0 = a0; writedata0 = d0;
        read1 = r1; write1 = w1; address1 = a1; writedata1 = d1;
        done = '{0, 0}; stall = '{0, 0}; first_s = '{-1, -1}; done_c = '{0, 0};
        idx = 0; cyc = 0;
        while (idx < n && cyc < 300) begin
            @(negedge clock);
            if (rst_at > 0 && cyc == rst_at) begin
                reset = 1'b1; #1;
                chk("rst_mid_mem_read", mem_read, 1'b0);
                chk("rst_mid_mem_write", mem_write, 1'b0);
                chk("rst_mid_readdata0", readdata0, 32'd0);
                chk("rst_mid_busywait0", busywait0, act[0]);
                cur[0] = '0; cur[1] = '0;
                @(posedge clock); @(posedge clock); #1 reset = 1'b0;
            end
            p = order[idx];
            if (mem_read || mem_write) begin
                if (first_s[p] < 0) first_s[p] = cyc;
                chk($sformatf("mem_address_p%0d", p), mem_address, aq[p]);
                chk($sformatf("mem_write_p%0d", p), mem_write, wq[p]);
                chk($sformatf("mem_read_p%0d", p), mem_read, rq[p] & ~wq[p]);
                if (wq[p]) chk($sformatf("mem_writedata_p%0d", p), mem_writedata, dq[p]);
            end
            if (n == 2) chk($sformatf("other_stalled_p%0d", order[1 - idx]),
                            (order[1 - idx] == 0) ? busywait0 : busywait1, !done[order[1 - idx]]);
            if (((p == 0) ? busywait0 : busywait1) === 1'b1) begin
                stall[p]++;
            end else begin
                cur[p] = comp[p];
                chk($sformatf("done_readdata0_p%0d", p), readdata0, cur[0]);
                chk($sformatf("done_readdata1_p%0d", p), readdata1, cur[1]);
                done[p] = 1'b1;
                done_c[p] = cyc;
                idx++;
            end
            cyc++;
            @(posedge clock); #1;
            if (done[0]) begin read0 = 1'b0; write0 = 1'b0; end
            if (done[1]) begin read1 = 1'b0; write1 = 1'b0; end
        end
        chk("completions", idx, n);
        if (rst_at == 0 && n > 0) begin
            chk($sformatf("stall_cycles_p%0d", order[0]), stall[order[0]], lat + 2);
            chk($sformatf("strobe_delay_p%0d", order[0]), first_s[order[0]], 1);
        end
        if (n == 2)
            chk("grant_from_done", first_s[order[1]], done_c[order[0]] + 1);
        @(negedge clock);
        chk("idle_readdata0", readdata0, exp_rd[0]);
        chk("idle_readdata1", readdata1, exp_rd[1]);
    endtask

    initial begin
        bit r0, w0, r1, w1;
        for (int i = 0; i < 64; i++) begin
            store[i]   = $urandom;
            ref_mem[i] = store[i];
        end
        store[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        reset = 1'b1;
        #2;
        chk("reset_readdata0", readdata0, 32'd0);
        chk("reset_readdata1", readdata1, 32'd0);
        chk("reset_mem_read", mem_read, 1'b0);
        chk("reset_mem_write", mem_write, 1'b0);
        chk("reset_mem_address", mem_address, 6'd0);
        chk("reset_mem_writedata", mem_writedata, 32'd0);
        chk("reset_busywait0_idle", busywait0, 1'b0);
        read0 = 1'b1; #1;
        chk("reset_busywait0_req", busywait0, 1'b1);
        read0 = 1'b0;
        @(posedge clock); #1 reset = 1'b0;

        run(1, 0, 6'h05, 32'd0, 0, 0, 6'd0, 32'd0, 5, 0);
        run(0, 0, 6'd0, 32'd0, 0, 1, 6'h3F, 32'h12345678, $urandom_range(1, 6), 0);
        run(1, 0, 6'h3F, 32'd0, 0, 0, 6'd0, 32'd0, 2, 0);
        run(1, 0, 6'($urandom_range(0, 63)), 32'd0, 1, 0, 6'($urandom_range(0, 63)), 32'd0, $urandom_range(1, 6), 0);
        run(1, 0, 6'($urandom_range(0, 63)), 32'd0, 1, 0, 6'($urandom_range(0, 63)), 32'd0, $urandom_range(1, 6), 0);
        run(1, 1, 6'h11, $urandom, 0, 0, 6'd0, 32'd0, 3, 0);
        run(0, 0, 6'd0, 32'd0, 1, 0, 6'h11, 32'd0, 1, 0);
        run(1, 0, 6'h2A, 32'd0, 0, 0, 6'd0, 32'd0, 6, 3);

        for (int s = 0; s < 10; s++) begin
            r0 = $urandom_range(0, 1); w0 = $urandom_range(0, 1);
            r1 = $urandom_range(0, 1); w1 = $urandom_range(0, 1);
            if (!(r0 | w0 | r1 | w1)) r1 = 1'b1;
            run(r0, w0, 6'($urandom_range(0, 63)), $urandom,
                r1, w1, 6'($urandom_range(0, 63)), $urandom, $urandom_range(1, 6), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
